// File: rtl/l2_bus_responder.sv
// Dummy L2 memory behind the coherence bus controller: single-word read/write
// with a fixed number of busy cycles, byte-lane writes and a one-cycle error response.
module l2_bus_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        l2REN,
  input  logic        l2WEN,
  input  logic [31:0] l2addr,
  input  logic [31:0] l2store,
  input  logic [3:0]  l2_byte_en,
  output logic [1:0]  l2state,
  output logic [31:0] l2load
);

  localparam int unsigned IdxW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned CntW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    L2_FREE   = 2'd0,
    L2_BUSY   = 2'd1,
    L2_ACCESS = 2'd2,
    L2_ERROR  = 2'd3
  } l2_state_t;

  l2_state_t         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              op_wr_q, op_wr_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [31:0]       store_q, store_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       load_q;
  logic [31:0]       mem [MEM_WORDS];

  logic [31:0]       offset;
  logic              req_valid;
  logic              req_held;
  logic              do_access;

  // Word index is taken relative to BASE_ADDR with wrapping 32-bit subtraction.
  assign offset    = l2addr - BASE_ADDR;
  assign req_valid = (l2addr[1:0] == 2'b00) && (offset[31:2] < 30'(MEM_WORDS)) &&
                     !(l2REN && l2WEN);
  assign req_held  = op_wr_q ? l2WEN : l2REN;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_wr_d   = op_wr_q;
    idx_d     = idx_q;
    store_d   = store_q;
    be_d      = be_q;
    do_access = 1'b0;
    unique case (state_q)
      L2_FREE: begin
        if (l2REN || l2WEN) begin
          if (req_valid) begin
            op_wr_d = l2WEN;
            idx_d   = offset[IdxW+1:2];
            store_d = l2store;
            be_d    = l2_byte_en;
            cnt_d   = CntW'(LATENCY);
            state_d = L2_BUSY;
          end else begin
            state_d = L2_ERROR;
          end
        end
      end
      L2_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        // A dropped request wins over completion, even on the final busy cycle.
        if (!req_held) begin
          state_d = L2_FREE;
        end else if (cnt_q == CntW'(1)) begin
          do_access = 1'b1;
          state_d   = L2_ACCESS;
        end
      end
      L2_ACCESS: state_d = L2_FREE;
      L2_ERROR:  state_d = L2_FREE;
      default:   state_d = L2_FREE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= L2_FREE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      store_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      store_q <= store_d;
      be_q    <= be_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) begin
        mem[i] <= '0;
      end
    end else if (do_access && op_wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem[idx_q][8*b +: 8] <= store_q[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      load_q <= '0;
    end else if (do_access && !op_wr_q) begin
      load_q <= mem[idx_q];
    end
  end

  assign l2state = state_q;
  assign l2load  = load_q;

endmodule

// File: tb/tb_l2_bus_responder.sv
// Directed bench for l2_bus_responder: timing, byte merge, errors, aborts, held requests.
module tb_l2_bus_responder;

  localparam int unsigned MemWords = 1024;
  localparam int unsigned Lat      = 4;
  localparam logic [31:0] Base     = 32'h0000_0000;

  localparam logic [1:0] SFree   = 2'd0;
  localparam logic [1:0] SBusy   = 2'd1;
  localparam logic [1:0] SAccess = 2'd2;
  localparam logic [1:0] SError  = 2'd3;

  logic        CLK = 1'b0;
  logic        RST;
  logic        l2REN;
  logic        l2WEN;
  logic [31:0] l2addr;
  logic [31:0] l2store;
  logic [3:0]  l2_byte_en;
  logic [1:0]  l2state;
  logic [31:0] l2load;

  int n_checks = 0;
  int n_fail   = 0;

  l2_bus_responder #(
    .MEM_WORDS(MemWords),
    .LATENCY  (Lat),
    .BASE_ADDR(Base)
  ) u_dut (
    .CLK       (CLK),
    .RST       (RST),
    .l2REN     (l2REN),
    .l2WEN     (l2WEN),
    .l2addr    (l2addr),
    .l2store   (l2store),
    .l2_byte_en(l2_byte_en),
    .l2state   (l2state),
    .l2load    (l2load)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Full transaction; alt_addr is applied after the first busy cycle and must be ignored.
  task automatic txn(input string tag, input bit wr, input logic [31:0] addr,
                     input logic [31:0] alt_addr, input logic [31:0] data,
                     input logic [3:0] be, output logic [31:0] load);
    check_eq({tag, " idle"}, 32'(l2state), 32'(SFree));
    l2REN      = !wr;
    l2WEN      = wr;
    l2addr     = addr;
    l2store    = data;
    l2_byte_en = be;
    for (int i = 0; i < int'(Lat); i++) begin
      tick();
      check_eq($sformatf("%s busy%0d", tag, i), 32'(l2state), 32'(SBusy));
      l2addr     = alt_addr;
      l2store    = ~data;
      l2_byte_en = ~be;
    end
    tick();
    check_eq({tag, " access"}, 32'(l2state), 32'(SAccess));
    load  = l2load;
    l2REN = 1'b0;
    l2WEN = 1'b0;
    tick();
    check_eq({tag, " free"}, 32'(l2state), 32'(SFree));
  endtask

  task automatic err_req(input string tag, input bit ren, input bit wen,
                         input logic [31:0] addr, input logic [31:0] load_exp);
    l2REN      = ren;
    l2WEN      = wen;
    l2addr     = addr;
    l2store    = 32'hFFFF_FFFF;
    l2_byte_en = 4'hF;
    tick();
    check_eq({tag, " error"}, 32'(l2state), 32'(SError));
    l2REN = 1'b0;
    l2WEN = 1'b0;
    tick();
    check_eq({tag, " free"}, 32'(l2state), 32'(SFree));
    check_eq({tag, " load kept"}, l2load, load_exp);
  endtask

  logic [31:0] rd;

  initial begin
    RST = 1'b1; l2REN = 1'b0; l2WEN = 1'b0;
    l2addr = '0; l2store = '0; l2_byte_en = '0;
    tick();
    check_eq("reset state", 32'(l2state), 32'(SFree));
    check_eq("reset load", l2load, 32'h0);
    RST = 1'b0;
    tick();

    txn("wr10", 1'b1, 32'h10, 32'h10, 32'hDEAD_BEEF, 4'hF, rd);
    txn("rd10", 1'b0, 32'h10, 32'h10, 32'h0, 4'h0, rd);
    check_eq("rd10 data", rd, 32'hDEAD_BEEF);

    txn("wr20", 1'b1, 32'h20, 32'h20, 32'h1122_3344, 4'hF, rd);
    txn("wr20be", 1'b1, 32'h20, 32'h20, 32'hAABB_CCDD, 4'b0101, rd);
    txn("rd20", 1'b0, 32'h20, 32'h20, 32'h0, 4'hF, rd);
    check_eq("merge data", rd, 32'h11BB_33DD);

    // Invalid writes would land on word 4 or word 0 if they leaked through.
    err_req("misalign", 1'b0, 1'b1, 32'h13, 32'h11BB_33DD);
    err_req("range", 1'b0, 1'b1, Base + 4 * MemWords, 32'h11BB_33DD);
    err_req("both", 1'b1, 1'b1, 32'h10, 32'h11BB_33DD);
    txn("rd10b", 1'b0, 32'h10, 32'h10, 32'h0, 4'h0, rd);
    check_eq("no misalign/both write", rd, 32'hDEAD_BEEF);
    txn("rd00", 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, rd);
    check_eq("no range write", rd, 32'h0);

    // Write abort by dropping WEN after two busy cycles.
    l2WEN = 1'b1; l2addr = 32'h40; l2store = 32'h5; l2_byte_en = 4'hF;
    tick();
    tick();
    check_eq("abort busy", 32'(l2state), 32'(SBusy));
    l2WEN = 1'b0;
    tick();
    check_eq("abort free", 32'(l2state), 32'(SFree));
    txn("rd40", 1'b0, 32'h40, 32'h40, 32'h0, 4'h0, rd);
    check_eq("abort no commit", rd, 32'h0);

    // Held read: one FREE turnaround cycle, then a fresh busy sequence.
    l2REN = 1'b1; l2addr = 32'h10;
    for (int i = 0; i < int'(Lat); i++) tick();
    tick();
    check_eq("held access", 32'(l2state), 32'(SAccess));
    check_eq("held data", l2load, 32'hDEAD_BEEF);
    tick();
    check_eq("held turnaround", 32'(l2state), 32'(SFree));
    tick();
    check_eq("held rebusy", 32'(l2state), 32'(SBusy));
    for (int i = 1; i < int'(Lat); i++) tick();
    tick();
    check_eq("held access2", 32'(l2state), 32'(SAccess));
    l2REN = 1'b0;
    tick();

    txn("rdlatch", 1'b0, 32'h10, 32'h20, 32'h0, 4'h0, rd);
    check_eq("latched addr", rd, 32'hDEAD_BEEF);

    // Reset mid-busy aborts the write.
    l2WEN = 1'b1; l2addr = 32'h44; l2store = 32'h7; l2_byte_en = 4'hF;
    tick();
    tick();
    RST = 1'b1;
    tick();
    check_eq("rst abort free", 32'(l2state), 32'(SFree));
    check_eq("rst abort load", l2load, 32'h0);
    RST = 1'b0; l2WEN = 1'b0;
    tick();
    txn("rd44", 1'b0, 32'h44, 32'h44, 32'h0, 4'h0, rd);
    check_eq("rst no commit", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
